// File: rtl/tx_slot_scheduler.sv
// TDMA transmit sequencer: slot timing, carrier sense, bounded retry/backoff.
// Optional macro TX_SLOT_LFSR_BACKOFF_EN selects LFSR-randomised backoff.
module tx_slot_scheduler #(
    parameter int SLOT_CYCLES = 256,
    parameter int NUM_SLOTS   = 64,
    parameter int TX_GUARD    = 32,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       frame_sync,
    input  logic [5:0] my_timeslot,
    input  logic       pkt_ready,
    input  logic       channel_clear,
    input  logic       tx_ack,
    output logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_drop,
    output logic [5:0] cur_slot,
    output logic [1:0] retry_cnt
);
    localparam int CW      = $clog2(SLOT_CYCLES);
    localparam int LAST_OK = SLOT_CYCLES - 1 - TX_GUARD;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SLOT,
        S_SENSE,
        S_BACKOFF,
        S_TX,
        S_DONE,
        S_DROP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [5:0]    slot_q, slot_d;
    logic          synced_q, synced_d;
    logic [1:0]    retry_q, retry_d;
    logic [5:0]    bo_q, bo_d, bo_load;
    logic          slot_ok;

    // frame_sync wins over the natural slot/frame wrap
    always_comb begin
        cyc_d    = cyc_q + CW'(1);
        slot_d   = slot_q;
        synced_d = synced_q;
        if (frame_sync) begin
            cyc_d    = '0;
            slot_d   = '0;
            synced_d = 1'b1;
        end else if (cyc_q == CW'(SLOT_CYCLES - 1)) begin
            cyc_d  = '0;
            slot_d = (slot_q == 6'(NUM_SLOTS - 1)) ? 6'd0 : slot_q + 6'd1;
        end
    end

    assign slot_ok = (slot_q == my_timeslot) && (int'(cyc_q) <= LAST_OK);

`ifdef TX_SLOT_LFSR_BACKOFF_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                       lfsr_q[15:1]};
        end
    end

    // counter holds length-1; mask uses the incremented retry count
    assign bo_load = lfsr_q[5:0] & ((6'd8 << retry_q) - 6'd1);
`else
    assign bo_load = (6'd4 << retry_q) - 6'd1;
`endif

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        bo_d     = bo_q;
        tx_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pkt_ready && synced_q) begin
                    state_d = S_WAIT_SLOT;
                    retry_d = '0;
                end
            end
            S_WAIT_SLOT: begin
                if (slot_ok) state_d = S_SENSE;
            end
            S_SENSE: begin
                if (channel_clear) begin
                    state_d  = S_TX;
                    tx_start = 1'b1;
                end else if (int'(retry_q) < MAX_RETRY) begin
                    state_d = S_BACKOFF;
                    retry_d = retry_q + 2'd1;
                    bo_d    = bo_load;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_BACKOFF: begin
                if (bo_q == 6'd0) begin
                    state_d = slot_ok ? S_SENSE : S_WAIT_SLOT;
                end else begin
                    bo_d = bo_q - 6'd1;
                end
            end
            S_TX: begin
                if (tx_ack) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_DROP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q  <= S_IDLE;
            cyc_q    <= '0;
            slot_q   <= '0;
            synced_q <= 1'b0;
            retry_q  <= '0;
            bo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            slot_q   <= slot_d;
            synced_q <= synced_d;
            retry_q  <= retry_d;
            bo_q     <= bo_d;
        end
    end

    assign tx_busy   = (state_q == S_WAIT_SLOT) || (state_q == S_SENSE) ||
                       (state_q == S_BACKOFF) || (state_q == S_TX);
    assign tx_done   = (state_q == S_DONE);
    assign tx_drop   = (state_q == S_DROP);
    assign cur_slot  = slot_q;
    assign retry_cnt = retry_q;
endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Self-checking bench for tx_slot_scheduler (default build, deterministic backoff).
// Expected timing comes from slot arithmetic over cycles elapsed since frame_sync.
module tb_tx_slot_scheduler;
    localparam int SC    = 256;
    localparam int NS    = 64;
    localparam int GUARD = 32;
    localparam int FRAME = SC * NS;

    logic       clk = 1'b0;
    logic       nrst = 1'b1;
    logic       frame_sync = 1'b0;
    logic [5:0] my_timeslot = 6'd0;
    logic       pkt_ready = 1'b0;
    logic       channel_clear = 1'b0;
    logic       tx_ack = 1'b0;
    logic       tx_start, tx_busy, tx_done, tx_drop;
    logic [5:0] cur_slot;
    logic [1:0] retry_cnt;

    int total = 0;
    int bad = 0;
    int unsigned ref_t;

    tx_slot_scheduler #(
        .SLOT_CYCLES(SC),
        .NUM_SLOTS(NS),
        .TX_GUARD(GUARD),
        .MAX_RETRY(3)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .frame_sync(frame_sync),
        .my_timeslot(my_timeslot),
        .pkt_ready(pkt_ready),
        .channel_clear(channel_clear),
        .tx_ack(tx_ack),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .tx_drop(tx_drop),
        .cur_slot(cur_slot),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // cycles elapsed since the last frame_sync (or reset)
    always @(posedge clk or posedge nrst) begin
        if (nrst) ref_t <= 0;
        else if (frame_sync) ref_t <= 0;
        else ref_t <= ref_t + 1;
    end

    function automatic int slot_of(input int unsigned t);
        return int'((t / SC) % NS);
    endfunction

    function automatic bit ok_at(input int unsigned t, input int my);
        return (slot_of(t) == my) && (int'(SC - 1 - (t % SC)) >= GUARD);
    endfunction

    function automatic int unsigned first_ok(input int unsigned from, input int my);
        int unsigned t = from;
        while (!ok_at(t, my)) t++;
        return t;
    endfunction

    function automatic int unsigned backoff_len(input int k);
        return 4 << (k - 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one packet: accepted at cycle acc, first n_busy senses busy (4 = drop)
    task automatic run_packet(input int my, input int n_busy,
                              input int unsigned acc, input int ack_dly,
                              input string tag);
        int unsigned sense[4];
        int unsigned e, ts, deadline, exp_start;
        bit started, finished;
        my_timeslot = 6'(my);
        pkt_ready = 0;
        channel_clear = 0;
        tx_ack = 0;
        frame_sync = 1;
        step();
        frame_sync = 0;
        sense[0] = first_ok(acc + 1, my) + 1;
        for (int k = 1; k < 4; k++) begin
            e = sense[k-1] + backoff_len(k);
            sense[k] = ok_at(e, my) ? e + 1 : first_ok(e + 1, my) + 1;
        end
        exp_start = (n_busy < 4) ? sense[n_busy] : 0;
        deadline = ((n_busy < 4) ? exp_start + ack_dly : sense[3]) + 40;
        started = 0;
        finished = 0;
        ts = 0;
        while (!finished && ref_t <= deadline) begin
            pkt_ready = (ref_t >= acc);
            channel_clear = (n_busy < 4) && (ref_t >= exp_start);
            tx_ack = (ref_t == acc + 1) || (started && ref_t == ts + ack_dly);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (k <= n_busy && ref_t == sense[k]) begin
                    total++;
                    if (retry_cnt !== 2'(k) || tx_busy !== 1'b1) begin
                        bad++;
                        $display("FAIL %s sense%0d: retry=%0d busy=%0b required retry=%0d busy=1",
                                 tag, k, retry_cnt, tx_busy, k);
                    end
                end
            end
            if (tx_start === 1'b1) begin
                total++;
                if (started || n_busy == 4 || ref_t != exp_start || int'(cur_slot) != my) begin
                    bad++;
                    $display("FAIL %s tx_start: t=%0d slot=%0d required t=%0d slot=%0d (n_busy=%0d)",
                             tag, ref_t, cur_slot, exp_start, my, n_busy);
                end
                started = 1;
                ts = ref_t;
            end
            if (tx_done === 1'b1) begin
                total++;
                if (!started || ref_t != ts + ack_dly + 1 || tx_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s tx_done: t=%0d busy=%0b required t=%0d busy=0",
                             tag, ref_t, tx_busy, ts + ack_dly + 1);
                end
                finished = 1;
                pkt_ready = 0;
            end
            if (tx_drop === 1'b1) begin
                total++;
                if (n_busy != 4 || started || ref_t != sense[3] + 1 || tx_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s tx_drop: t=%0d busy=%0b required t=%0d busy=0 n_busy=4",
                             tag, ref_t, tx_busy, sense[3] + 1);
                end
                finished = 1;
                pkt_ready = 0;
            end
            step();
        end
        tx_ack = 0;
        pkt_ready = 0;
        channel_clear = 0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s timeout: finished=0 required=1", tag);
        end
        #1;
        total++;
        if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_drop !== 1'b0) begin
            bad++;
            $display("FAIL %s idle_after: busy=%0b done=%0b drop=%0b required 0/0/0",
                     tag, tx_busy, tx_done, tx_drop);
        end
    endtask

    task automatic test_reset();
        nrst = 1;
        repeat (3) step();
        total++;
        if (cur_slot !== 6'd0 || retry_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_counts: slot=%0d retry=%0d required 0/0", cur_slot, retry_cnt);
        end
        total++;
        if (tx_busy !== 1'b0 || tx_start !== 1'b0 || tx_done !== 1'b0 || tx_drop !== 1'b0) begin
            bad++;
            $display("FAIL reset_outs: busy=%0b start=%0b done=%0b drop=%0b required all 0",
                     tx_busy, tx_start, tx_done, tx_drop);
        end
        nrst = 0;
    endtask

    task automatic test_presync();
        int hits = 0;
        my_timeslot = 6'd2;
        pkt_ready = 1;
        channel_clear = 1;
        for (int i = 0; i < 900; i++) begin
            step();
            if (tx_busy !== 1'b0 || tx_start !== 1'b0) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL presync_idle: active_cycles=%0d required 0", hits);
        end
        total++;
        if (int'(cur_slot) != slot_of(ref_t)) begin
            bad++;
            $display("FAIL presync_freerun: slot=%0d required %0d", cur_slot, slot_of(ref_t));
        end
        run_packet(2, 0, 0, 10, "presync_tx");
    endtask

    task automatic test_clear_tx();
        for (int i = 0; i < 3; i++) begin
            int my = int'($urandom_range(0, 3));
            run_packet(my, 0, $urandom_range(0, my * SC + 100),
                       int'($urandom_range(1, 20)), "clear_tx");
        end
    endtask

    task automatic test_retry();
        for (int i = 0; i < 3; i++) begin
            int my = int'($urandom_range(0, 3));
            run_packet(my, int'($urandom_range(1, 3)), $urandom_range(0, my * SC + 100),
                       int'($urandom_range(1, 20)), "retry");
        end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 2; i++) begin
            int my = int'($urandom_range(0, 3));
            run_packet(my, 4, $urandom_range(0, my * SC + 100), 1, "drop");
        end
    endtask

    task automatic test_defer();
        int my = int'($urandom_range(0, 3));
        run_packet(my, 1, my * SC + 222, int'($urandom_range(1, 20)), "defer");
    endtask

    task automatic test_reset_in_tx();
        bit seen = 0;
        int hits = 0;
        my_timeslot = 6'd1;
        channel_clear = 1;
        frame_sync = 1;
        step();
        frame_sync = 0;
        pkt_ready = 1;
        for (int i = 0; i < 700 && !seen; i++) begin
            #1;
            if (tx_start === 1'b1) seen = 1;
            step();
        end
        pkt_ready = 0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_tx_start: seen=0 required 1");
        end
        repeat (3) step();
        nrst = 1;
        #1;
        total++;
        if (tx_busy !== 1'b0 || cur_slot !== 6'd0 || retry_cnt !== 2'd0 ||
            tx_done !== 1'b0 || tx_drop !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_tx: busy=%0b slot=%0d retry=%0d done=%0b drop=%0b required 0",
                     tx_busy, cur_slot, retry_cnt, tx_done, tx_drop);
        end
        step();
        nrst = 0;
        tx_ack = 1;
        step();
        tx_ack = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_done !== 1'b0 || tx_busy !== 1'b0 || tx_start !== 1'b0) hits++;
            step();
        end
        channel_clear = 0;
        total++;
        if (hits != 0) begin
            bad++;
            $display("FAIL rst_late_ack: active_cycles=%0d required 0", hits);
        end
    endtask

    task automatic test_frame_resync();
        frame_sync = 1;
        step();
        frame_sync = 0;
        while (ref_t < 40 * SC + 100) step();
        total++;
        if (cur_slot !== 6'd40) begin
            bad++;
            $display("FAIL resync_pre: slot=%0d required 40", cur_slot);
        end
        frame_sync = 1;
        step();
        frame_sync = 0;
        total++;
        if (cur_slot !== 6'd0) begin
            bad++;
            $display("FAIL resync_now: slot=%0d required 0", cur_slot);
        end
        while (ref_t < SC - 1) step();
        total++;
        if (cur_slot !== 6'd0) begin
            bad++;
            $display("FAIL resync_cyc255: slot=%0d required 0", cur_slot);
        end
        step();
        total++;
        if (cur_slot !== 6'd1) begin
            bad++;
            $display("FAIL resync_cyc256: slot=%0d required 1", cur_slot);
        end
    endtask

    task automatic test_wrap();
        while (ref_t < 2 * FRAME + 2) begin
            step();
            if (ref_t % SC == 0 || ref_t % SC == SC - 1) begin
                total++;
                if (int'(cur_slot) != slot_of(ref_t)) begin
                    bad++;
                    $display("FAIL wrap t=%0d: slot=%0d required %0d",
                             ref_t, cur_slot, slot_of(ref_t));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_presync();
        test_clear_tx();
        test_retry();
        test_drop();
        test_defer();
        test_reset_in_tx();
        test_frame_resync();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
